// File: rtl/spi_rsp_capture_if.sv
// ---------------------------------------------------------------------------
// spi_rsp_capture_if
// Bundles the SPI pins and the captured-word read port of spi_rsp_capture.
//   SPI side : spi_sclk_i, spi_cs_i (active-low), spi_mosi_i, spi_miso_i
//   Read side: rd_en_i (pop), rd_data_o (FIFO head), rd_valid_o (non-empty),
//              level_o (occupancy)
//   Status   : overflow_o (sticky drop), frame_err_o (pulse), word_cnt_o
// Modport slave is the capture block; modport master is whoever drives the
// SPI lines and drains the FIFO.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface spi_rsp_capture_if #(
   parameter int unsigned FIFO_DEPTH = 8
);
   localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

   logic          spi_sclk_i;
   logic          spi_cs_i;
   logic          spi_mosi_i;
   logic          spi_miso_i;
   logic          rd_en_i;
   logic [31:0]   rd_data_o;
   logic          rd_valid_o;
   logic [LW-1:0] level_o;
   logic          overflow_o;
   logic          frame_err_o;
   logic [15:0]   word_cnt_o;

   modport master (
      output spi_sclk_i, spi_cs_i, spi_mosi_i, spi_miso_i, rd_en_i,
      input  rd_data_o, rd_valid_o, level_o, overflow_o, frame_err_o, word_cnt_o
   );

   modport slave (
      input  spi_sclk_i, spi_cs_i, spi_mosi_i, spi_miso_i, rd_en_i,
      output rd_data_o, rd_valid_o, level_o, overflow_o, frame_err_o, word_cnt_o
   );
endinterface

// File: rtl/spi_rsp_capture.sv
// ---------------------------------------------------------------------------
// spi_rsp_capture
// Passively snoops an SPI bus, decodes register/memory read commands on MOSI
// and captures the 32-bit response words from MISO into a FWFT FIFO.
//   clk_sys_i : system clock, all logic on rising edge
//   rst_i     : asynchronous, active-high reset
//   bus       : spi_rsp_capture_if.slave (SPI pins, FIFO read port, status)
// Several read transactions may follow each other inside one CS frame.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module spi_rsp_capture #(
   parameter logic [7:0]  CMD_RD_REG = 8'h07,
   parameter logic [7:0]  CMD_RD_MEM = 8'h0B,
   parameter int unsigned DUMMY_REG  = 1,
   parameter int unsigned DUMMY_MEM  = 34,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input logic               clk_sys_i,
   input logic               rst_i,
   spi_rsp_capture_if.slave  bus
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam logic [5:0]  DUMMY_REG_C = 6'(DUMMY_REG);
   localparam logic [5:0]  DUMMY_MEM_C = 6'(DUMMY_MEM);

   typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_SKIP} state_t;

   // Synchronizers: [0],[1] are the 2-flop synchronizer, [2] the edge-detect flop
   logic [2:0] sclk_sync_q, cs_sync_q, mosi_sync_q, miso_sync_q;

   always_ff @(posedge clk_sys_i or posedge rst_i) begin
      if (rst_i) begin
         sclk_sync_q <= 3'b000;
         cs_sync_q   <= 3'b111;
         mosi_sync_q <= 3'b000;
         miso_sync_q <= 3'b000;
      end else begin
         sclk_sync_q <= {sclk_sync_q[1:0], bus.spi_sclk_i};
         cs_sync_q   <= {cs_sync_q[1:0],   bus.spi_cs_i};
         mosi_sync_q <= {mosi_sync_q[1:0], bus.spi_mosi_i};
         miso_sync_q <= {miso_sync_q[1:0], bus.spi_miso_i};
      end
   end

   logic sample_evt, cs_fall, cs_rise, mosi_s, miso_s;
   assign sample_evt = sclk_sync_q[1] & ~sclk_sync_q[2];
   assign cs_fall    = ~cs_sync_q[1] &  cs_sync_q[2];
   assign cs_rise    =  cs_sync_q[1] & ~cs_sync_q[2];
   // Data is taken from the edge-detect stage, i.e. the value present just
   // before SCLK rose, which is where the master holds it stable.
   assign mosi_s     = mosi_sync_q[2];
   assign miso_s     = miso_sync_q[2];

   // Capture FSM
   state_t      state_q, state_d;
   logic [5:0]  bit_cnt_q, bit_cnt_d;
   logic [5:0]  dummy_len_q, dummy_len_d;
   logic [30:0] shift_q, shift_d;
   logic        frame_err_q, frame_err_d;
   logic        push;
   logic [7:0]  cmd_byte;
   logic [31:0] push_data;

   assign cmd_byte  = {shift_q[6:0], mosi_s};
   assign push_data = {shift_q, miso_s};

   always_ff @(posedge clk_sys_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         bit_cnt_q   <= '0;
         dummy_len_q <= '0;
         shift_q     <= '0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         dummy_len_q <= dummy_len_d;
         shift_q     <= shift_d;
         frame_err_q <= frame_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      dummy_len_d = dummy_len_q;
      shift_d     = shift_q;
      frame_err_d = 1'b0;
      push        = 1'b0;
      if (cs_rise) begin
         // CS rise always aborts; it is only an error if a transaction was in progress
         state_d   = S_IDLE;
         bit_cnt_d = '0;
         if ((state_q inside {S_ADDR, S_DUMMY, S_DATA}) ||
             (state_q == S_CMD && bit_cnt_q != 6'd0))
            frame_err_d = 1'b1;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (cs_fall) begin
                  state_d   = S_CMD;
                  bit_cnt_d = '0;
               end
            end
            S_CMD: begin
               if (sample_evt) begin
                  shift_d   = {shift_q[29:0], mosi_s};
                  bit_cnt_d = bit_cnt_q + 6'd1;
                  if (bit_cnt_q == 6'd7) begin
                     bit_cnt_d = '0;
                     if (cmd_byte == CMD_RD_MEM) begin
                        state_d = S_ADDR;
                     end else if (cmd_byte == CMD_RD_REG) begin
                        dummy_len_d = DUMMY_REG_C;
                        state_d     = (DUMMY_REG_C == 6'd0) ? S_DATA : S_DUMMY;
                     end else begin
                        state_d = S_SKIP;
                     end
                  end
               end
            end
            S_ADDR: begin
               if (sample_evt) begin
                  bit_cnt_d = bit_cnt_q + 6'd1;
                  if (bit_cnt_q == 6'd31) begin
                     bit_cnt_d   = '0;
                     dummy_len_d = DUMMY_MEM_C;
                     state_d     = (DUMMY_MEM_C == 6'd0) ? S_DATA : S_DUMMY;
                  end
               end
            end
            S_DUMMY: begin
               if (sample_evt) begin
                  bit_cnt_d = bit_cnt_q + 6'd1;
                  if (bit_cnt_q == dummy_len_q - 6'd1) begin
                     bit_cnt_d = '0;
                     state_d   = S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (sample_evt) begin
                  shift_d   = {shift_q[29:0], miso_s};
                  bit_cnt_d = bit_cnt_q + 6'd1;
                  if (bit_cnt_q == 6'd31) begin
                     push      = 1'b1;
                     bit_cnt_d = '0;
                     state_d   = S_CMD;
                  end
               end
            end
            S_SKIP: ;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Captured-word FIFO (first-word-fall-through)
   logic [31:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [LW-1:0] level_q;
   logic          overflow_q;
   logic [15:0]   word_cnt_q;
   logic          full, fifo_pop, fifo_push, drop;

   assign full      = (level_q == LW'(FIFO_DEPTH));
   assign fifo_pop  = bus.rd_en_i & (level_q != '0);
   // A pop in the same cycle frees the slot the incoming word needs
   assign fifo_push = push & (~full | fifo_pop);
   assign drop      = push & full & ~fifo_pop;

   always_ff @(posedge clk_sys_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
         word_cnt_q <= '0;
      end else begin
         if (fifo_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (fifo_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         if (fifo_push && !fifo_pop)      level_q <= level_q + LW'(1);
         else if (!fifo_push && fifo_pop) level_q <= level_q - LW'(1);
         if (drop) overflow_q <= 1'b1;
         if (push && word_cnt_q != 16'hFFFF) word_cnt_q <= word_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk_sys_i) begin
      if (fifo_push) mem[wr_ptr_q] <= push_data;
   end

   assign bus.rd_valid_o  = (level_q != '0);
   // Storage is not reset, so the head is masked while the FIFO is empty
   assign bus.rd_data_o   = bus.rd_valid_o ? mem[rd_ptr_q] : 32'd0;
   assign bus.level_o     = level_q;
   assign bus.overflow_o  = overflow_q;
   assign bus.frame_err_o = frame_err_q;
   assign bus.word_cnt_o  = word_cnt_q;
endmodule

// File: doc/spi_rsp_capture.md
SPI_RSP_CAPTURE -- requirements
Module: spi_rsp_capture

Interface
REQ-001 Parameter CMD_RD_REG, default 8'h07, command byte selecting register read.
REQ-002 Parameter CMD_RD_MEM, default 8'h0B, command byte selecting memory read.
REQ-003 Parameter DUMMY_REG, default 1, dummy SCLK cycles after the command byte for register read.
REQ-004 Parameter DUMMY_MEM, default 34, dummy SCLK cycles after the address for memory read.
REQ-005 Parameter FIFO_DEPTH, default 8 (power of two), depth of the captured-word FIFO.
REQ-006 clk_sys_i  input  1  system clock; all logic on its rising edge.
REQ-007 rst_i  input  1  reset, asynchronous, active-high.
REQ-008 spi_sclk_i  input  1  SPI clock from the stimulus master, asynchronous to clk_sys_i.
REQ-009 spi_cs_i  input  1  SPI chip select, active-low.
REQ-010 spi_mosi_i  input  1  master-to-DUT data (command/address stream).
REQ-011 spi_miso_i  input  1  DUT-to-master read data.
REQ-012 rd_en_i  input  1  pop request for the FIFO head.
REQ-013 rd_data_o  output  32  FIFO head word (first-word-fall-through).
REQ-014 rd_valid_o  output  1  FIFO non-empty.
REQ-015 level_o  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-016 overflow_o  output  1  sticky: a captured word was dropped.
REQ-017 frame_err_o  output  1  one-cycle pulse: CS deasserted mid-transaction.
REQ-018 word_cnt_o  output  16  total words captured, saturating at 16'hFFFF.

Function
REQ-019 The block SHALL pass spi_sclk_i, spi_cs_i, spi_mosi_i, spi_miso_i each through a 2-flop synchronizer plus one edge-detect flop; a sample event is a synchronized SCLK 0->1 transition.
REQ-020 States SHALL be IDLE, CMD, ADDR, DUMMY, DATA, SKIP; a 6-bit bit counter tracks position within the current state.
REQ-021 IDLE -> CMD on synchronized CS 1->0, bit counter cleared.
REQ-022 CMD SHALL shift spi_mosi_i MSB-first on 8 sample events; on the 8th: cmd==CMD_RD_MEM -> ADDR; cmd==CMD_RD_REG -> DUMMY (DUMMY_REG); any other -> SKIP.
REQ-023 ADDR SHALL count 32 sample events (address not stored), then -> DUMMY (DUMMY_MEM).
REQ-024 DUMMY SHALL count the selected number of sample events, then -> DATA.
REQ-025 DATA SHALL shift spi_miso_i MSB-first; on the 32nd sample event the word is pushed to the FIFO in the same clk_sys_i cycle and the state -> CMD (back-to-back transactions within one CS frame).
REQ-026 SKIP SHALL ignore all sample events until CS deasserts.
REQ-027 Synchronized CS 0->1 in any state SHALL force IDLE; if in ADDR, DUMMY, DATA, or CMD with >=1 bit shifted, frame_err_o pulses one cycle and the partial word is discarded; CS rise from CMD with 0 bits or SKIP raises no error.
REQ-028 FIFO: push when not full; push when full and no pop -> word dropped, overflow_o set and held until reset.
REQ-029 Simultaneous push and pop when full SHALL both take effect, level unchanged, no overflow.
REQ-030 Pop SHALL occur only when rd_en_i && rd_valid_o; rd_en_i on empty is ignored.
REQ-031 A word pushed into an empty FIFO SHALL appear on rd_data_o with rd_valid_o=1 on the next cycle.
REQ-032 Read/write pointers SHALL be $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
REQ-033 word_cnt_o SHALL increment per captured word (including dropped ones), saturating.

Reset
REQ-034 While rst_i high: state IDLE, synchronizers CS=1 / SCLK=0 / data=0, FIFO empty, rd_data_o=0, rd_valid_o=0, level_o=0, overflow_o=0, frame_err_o=0, word_cnt_o=0.
REQ-035 rst_i asserted mid-transaction SHALL discard all in-flight and stored data; after release, capture restarts only on a new CS falling edge.

Verification
REQ-036 CS low, cmd 8'h0B, addr 32'h1000_0000, 34 dummy, MISO 32'hDEAD_BEEF, CS high -> rd_data_o=32'hDEAD_BEEF, rd_valid_o=1, level_o=1, frame_err_o never pulses.
REQ-037 One CS frame: cmd 8'h07, 1 dummy, MISO 32'h0000_00A5, then cmd 8'h0B read returning 32'h1234_5678 -> FIFO holds 32'h0000_00A5 then 32'h1234_5678, word_cnt_o=2.
REQ-038 cmd 8'h02 followed by 64 SCLK cycles of arbitrary MISO -> no push, no frame_err_o, level_o=0.
REQ-039 9 register reads, rd_en_i=0 -> level_o=8, overflow_o=1, word_cnt_o=9; 8 pops return words 1..8 in order.
REQ-040 CS high after 16 bits of DATA -> one-cycle frame_err_o, level_o unchanged; next full read captured correctly.
REQ-041 rst_i pulsed during ADDR with 3 words stored -> all outputs at reset values; subsequent read captured correctly.
